// File: rtl/gf_mul_serial.sv
// gf_mul_serial: digit-serial GF(2^WIDTH) multiplier, c = a*b mod (x^WIDTH + POLY); ports clk, rst_n, in_valid/in_ready/a/b in, out_valid/out_ready/c out
module gf_mul_serial #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = WIDTH'('h1B),
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad_params
    $error("gf_mul_serial: illegal WIDTH/DIGIT combination");
  end
  logic [1:0] state;
  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_nxt;
  logic [CW-1:0] cnt;
  function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
  endfunction
  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < DIGIT; i++) acc_nxt = xtime(acc_nxt) ^ (a_reg[WIDTH-1-i] ? b_reg : '0);
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc <= '0;
      cnt <= '0;
      c <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_reg <= a;
        b_reg <= b;
        acc <= '0;
        cnt <= CW'(N);
        state <= CALC;
      end
    end else if (state == CALC) begin
      acc <= acc_nxt;
      a_reg <= a_reg << DIGIT;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        c <= acc_nxt;
        state <= DONE;
      end
    end else if (out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_gf_mul_serial.sv
// tb_gf_mul_serial: self-checking bench for gf_mul_serial against a polynomial-arithmetic model
module tb_gf_mul_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic in_ready, out_valid;
  logic [7:0] c;
  logic x_valid = 1'b0, x_ready = 1'b0;
  logic [7:0] x_a = '0, x_b = '0;
  logic x2_ir, x2_ov, x8_ir, x8_ov, x4_ir, x4_ov;
  logic [7:0] x2_c, x8_c;
  logic [3:0] x4_c;
  int n_chk = 0, n_fail = 0;
  logic m_done;
  int m_left;
  logic [7:0] m_c, m_res;

  always #5 clk = ~clk;

  gf_mul_serial dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .c(c));
  gf_mul_serial #(.WIDTH(8), .POLY(8'h1B), .DIGIT(2)) u_d2 (.clk(clk), .rst_n(rst_n), .in_valid(x_valid),
    .in_ready(x2_ir), .a(x_a), .b(x_b), .out_valid(x2_ov), .out_ready(x_ready), .c(x2_c));
  gf_mul_serial #(.WIDTH(8), .POLY(8'h1B), .DIGIT(8)) u_d8 (.clk(clk), .rst_n(rst_n), .in_valid(x_valid),
    .in_ready(x8_ir), .a(x_a), .b(x_b), .out_valid(x8_ov), .out_ready(x_ready), .c(x8_c));
  gf_mul_serial #(.WIDTH(4), .POLY(4'h3), .DIGIT(1)) u_w4 (.clk(clk), .rst_n(rst_n), .in_valid(x_valid),
    .in_ready(x4_ir), .a(x_a[3:0]), .b(x_b[3:0]), .out_valid(x4_ov), .out_ready(x_ready), .c(x4_c));

  // schoolbook product over GF(2): add shifted copies of x for each set bit of y, reducing x as it grows
  function automatic logic [31:0] gfm(input logic [31:0] x, input logic [31:0] y, input int w, input logic [31:0] p);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      if (y[i]) r ^= x;
      x = x << 1;
      if (x[w]) x ^= (32'h1 << w) | p;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // transaction-level timing: busy for 8 steps after accept, then hold the product until taken
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_done <= 1'b0;
      m_left <= 0;
      m_c <= '0;
      m_res <= '0;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_c <= m_res;
      end
    end else if (in_valid) begin
      m_res <= 8'(gfm(32'(a), 32'(b), 8, 32'h1B));
      m_left <= 8;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'(!m_done && m_left == 0));
    chk("out_valid", 32'(out_valid), 32'(m_done));
    chk("c", 32'(c), 32'(m_c));
  end

  task automatic main_op(input logic [7:0] aa, input logic [7:0] bb, input logic [7:0] exp, input int hold);
    int n;
    in_valid = 1'b1; a = aa; b = bb; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'd8);
    chk("product", 32'(c), 32'(exp));
    repeat (hold) begin
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
      chk("bp_c", 32'(c), 32'(exp));
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ret_in_ready", 32'(in_ready), 32'd1);
    chk("ret_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic aux_op(input logic [7:0] aa, input logic [7:0] bb);
    logic [7:0] e8;
    logic [3:0] e4;
    int l2, l8, l4;
    e8 = 8'(gfm(32'(aa), 32'(bb), 8, 32'h1B));
    e4 = 4'(gfm(32'(aa[3:0]), 32'(bb[3:0]), 4, 32'h3));
    chk("aux_in_ready", 32'({x2_ir, x8_ir, x4_ir}), 32'h7);
    x_valid = 1'b1; x_a = aa; x_b = bb; x_ready = 1'b0;
    @(posedge clk); #1;
    x_a = 8'($urandom); x_b = 8'($urandom);
    l2 = 0; l8 = 0; l4 = 0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (x2_ov && l2 == 0) l2 = n;
      if (x8_ov && l8 == 0) l8 = n;
      if (x4_ov && l4 == 0) l4 = n;
    end
    chk("d2_latency", 32'(l2), 32'd4);
    chk("d8_latency", 32'(l8), 32'd1);
    chk("w4_latency", 32'(l4), 32'd4);
    chk("d2_c", 32'(x2_c), 32'(e8));
    chk("d8_c", 32'(x8_c), 32'(e8));
    chk("w4_c", 32'(x4_c), 32'(e4));
    x_valid = 1'b0; x_ready = 1'b1;
    @(posedge clk); #1;
    x_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    chk("model_57x83", gfm(32'h57, 32'h83, 8, 32'h1B), 32'hC1);
    chk("model_57x13", gfm(32'h57, 32'h13, 8, 32'h1B), 32'hFE);
    chk("model_01xA5", gfm(32'h01, 32'hA5, 8, 32'h1B), 32'hA5);
    chk("model_gf16_8x2", gfm(32'h8, 32'h2, 4, 32'h3), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c", 32'(c), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    main_op(8'h57, 8'h83, 8'hC1, 0);
    main_op(8'h57, 8'h13, 8'hFE, 0);
    main_op(8'h01, 8'hA5, 8'hA5, 0);
    main_op(8'h00, 8'hFF, 8'h00, 0);
    main_op(8'hA5, 8'h00, 8'h00, 0);
    main_op(8'h57, 8'h83, 8'hC1, 5);
    aux_op(8'h57, 8'h83);
    chk("d2_c_lit", 32'(x2_c), 32'hC1);
    chk("d8_c_lit", 32'(x8_c), 32'hC1);
    aux_op(8'h08, 8'h02);
    chk("w4_c_lit", 32'(x4_c), 32'h3);
    for (int i = 0; i < 256; i++) aux_op(8'(i >> 4), 8'(i & 15));
    in_valid = 1'b1; a = 8'h57; b = 8'h83; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_c", 32'(c), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("midrst_no_product", 32'(cnt), 32'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (30000) begin
      a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
